kmem_stream_ctrl: RTL

//  Upstream feeder for the learn/classify core. It owns one single-port kernel SRAM (KMEM, 32 x 32b).
//  In learn it streams incoming 32b words (4 x 8b pixels) into KMEM at sequential addresses.
//  In classify it reads the stored words back in order and presents them as pixels[3:0][7:0] via valid/ready.
//  It drives the active-low SRAM strobes (CSB/WEB/OEB) and the 5b address.

---
 rtl/kmem_stream_ctrl_pkg.sv | 35 +++
 rtl/kmem_stream_ctrl_if.sv | 36 +++
 rtl/kmem_stream_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/kmem_stream_ctrl_pkg.sv
// Shared constants, pixel bundle type and FSM state encoding for the kernel
// memory stream controller.
package kmem_stream_ctrl_pkg;

  localparam int ADDR_W = 5;
  localparam int PIX_W  = 8;
  localparam int NPIX   = 4;
  localparam int DATA_W = NPIX * PIX_W;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef logic [NPIX-1:0][PIX_W-1:0] pix4_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_REQ   = 3'd2,
    RD_CAP   = 3'd3,
    OUT_HOLD = 3'd4
  } kst_e;

  // Byte k of a stored word is pixel k.
  function automatic pix4_t word_to_pix(input logic [DATA_W-1:0] w);
    pix4_t p;
    for (int k = 0; k < NPIX; k++) begin
      p[k] = w[k*PIX_W +: PIX_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/kmem_stream_ctrl_if.sv
// Control, stream and SRAM signals of the kernel memory stream controller.
// The controller takes the slave view; the environment drives the master view.
interface kmem_stream_ctrl_if;
  import kmem_stream_ctrl_pkg::*;

  logic              learn;
  logic              classify;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  pix4_t             out_pixels;
  logic [CNT_W-1:0]  word_count;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] KMEM_ADD;
  logic              KMEM_CSB;
  logic              KMEM_WEB;
  logic              KMEM_OEB;
  logic [DATA_W-1:0] KMEM_DATA_O;
  logic [DATA_W-1:0] KMEM_DATA_I;

  modport slave (
    input  learn, classify, in_valid, in_data, out_ready, KMEM_DATA_I,
    output in_ready, out_valid, out_pixels, word_count, busy, done,
           KMEM_ADD, KMEM_CSB, KMEM_WEB, KMEM_OEB, KMEM_DATA_O
  );

  modport master (
    output learn, classify, in_valid, in_data, out_ready, KMEM_DATA_I,
    input  in_ready, out_valid, out_pixels, word_count, busy, done,
           KMEM_ADD, KMEM_CSB, KMEM_WEB, KMEM_OEB, KMEM_DATA_O
  );

endinterface

// File: rtl/kmem_stream_ctrl.sv
// Streams learn-mode words into the external kernel SRAM and replays them as
// 4-pixel beats in classify mode; SRAM strobes are active-low.
module kmem_stream_ctrl
  import kmem_stream_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  kmem_stream_ctrl_if.slave  bus
);

  kst_e             state_q, state_d;
  logic [CNT_W-1:0] wc_q, wc_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             out_valid_q, out_valid_d;
  pix4_t            pix_q, pix_d;
  logic             done_q, done_d;

  logic              in_ready_s;
  logic              wr_hs_s;
  logic              rd_stb_s;
  logic              csb_s;
  logic              web_s;
  logic              oeb_s;
  logic [ADDR_W-1:0] add_s;
  logic [DATA_W-1:0] data_o_s;

  // Next-state, counters and handshake decode.
  always_comb begin
    state_d     = state_q;
    wc_d        = wc_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    pix_d       = pix_q;
    done_d      = 1'b0;
    in_ready_s  = 1'b0;
    wr_hs_s     = 1'b0;
    rd_stb_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.learn) begin
          state_d = WRITE;
          wc_d    = CNT_ZERO;
        end else if (bus.classify) begin
          state_d  = RD_REQ;
          rd_ptr_d = CNT_ZERO;
        end else begin
          state_d = IDLE;
        end
      end

      WRITE: begin
        // Gating on learn keeps the cycle in which learn drops free of writes.
        in_ready_s = bus.learn && (wc_q < DEPTH_C);
        wr_hs_s    = in_ready_s && bus.in_valid;
        if (wr_hs_s) begin
          wc_d = wc_q + CNT_ONE;
        end else begin
          wc_d = wc_q;
        end
        if (!bus.learn || (wc_q == DEPTH_C)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = WRITE;
        end
      end

      RD_REQ: begin
        if (rd_ptr_q == wc_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          rd_stb_s = 1'b1;
          state_d  = RD_CAP;
        end
      end

      RD_CAP: begin
        pix_d       = word_to_pix(bus.KMEM_DATA_I);
        out_valid_d = 1'b1;
        state_d     = OUT_HOLD;
      end

      OUT_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          rd_ptr_d    = rd_ptr_q + CNT_ONE;
          state_d     = RD_REQ;
        end else begin
          state_d = OUT_HOLD;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // SRAM strobe, address and write-data decode.
  always_comb begin
    csb_s    = 1'b1;
    web_s    = 1'b1;
    oeb_s    = 1'b1;
    add_s    = {ADDR_W{1'b0}};
    data_o_s = {DATA_W{1'b0}};
    if (wr_hs_s) begin
      csb_s    = 1'b0;
      web_s    = 1'b0;
      add_s    = wc_q[ADDR_W-1:0];
      data_o_s = bus.in_data;
    end else if (rd_stb_s) begin
      csb_s = 1'b0;
      oeb_s = 1'b0;
      add_s = rd_ptr_q[ADDR_W-1:0];
    end else begin
      csb_s = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wc_q        <= CNT_ZERO;
      rd_ptr_q    <= CNT_ZERO;
      out_valid_q <= 1'b0;
      pix_q       <= pix4_t'({DATA_W{1'b0}});
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wc_q        <= wc_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      pix_q       <= pix_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pixels  = pix_q;
  assign bus.word_count  = wc_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_q;
  assign bus.KMEM_ADD    = add_s;
  assign bus.KMEM_CSB    = csb_s;
  assign bus.KMEM_WEB    = web_s;
  assign bus.KMEM_OEB    = oeb_s;
  assign bus.KMEM_DATA_O = data_o_s;

endmodule
